// File: rtl/readout_pkg.sv
// Shared types and default sizes for the spectrogram readout scheduler.
// Holds the FSM state enum and the word/source geometry defaults.
package readout_pkg;

   localparam int DEF_DATA_W  = 12;
   localparam int DEF_N_SRC   = 16;
   localparam int DEF_SEL_W   = 4;
   localparam int DEF_ID_W    = 8;
   localparam int WORD_CYCLES = DEF_DATA_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_CLEAR = 2'd3
   } state_e;

endpackage

// File: rtl/readout_scheduler_if.sv
// Datapath control bundle from the scheduler to the mux + PISO + counters.
// master drives sel/sl/shift_en/cnt_clr; slave is the datapath side.
interface readout_scheduler_if
   import readout_pkg::*;
#(
   parameter int SEL_W = DEF_SEL_W
);

   logic [SEL_W-1:0] sel;
   logic             sl;
   logic             shift_en;
   logic             cnt_clr;

   modport master (
      output sel,
      output sl,
      output shift_en,
      output cnt_clr
   );

   modport slave (
      input sel,
      input sl,
      input shift_en,
      input cnt_clr
   );

endinterface

// File: rtl/readout_scheduler_next_src_finder.sv
// Combinational search for the next enabled source in a mask.
// Ports: mask, cur, first in; idx, found out. first=1 searches from -1.
module next_src_finder
   import readout_pkg::*;
#(
   parameter int N_SRC = DEF_N_SRC,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic [N_SRC-1:0] mask,
   input  logic [SEL_W-1:0] cur,
   input  logic             first,
   output logic [SEL_W-1:0] idx,
   output logic             found
);

   // Walk downward so the last hit, the lowest index, wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (mask[i] && (first || i > int'(cur))) begin
            idx   = SEL_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/readout_scheduler.sv
// Readout frame sequencer: walks enabled sources, drives mux/PISO/clear.
// Ports: clk, reset(n), ovf_in, force_req, ch_mask, clr_overrun, dp, status.
module readout_scheduler
   import readout_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_SRC  = DEF_N_SRC,
   parameter int SEL_W  = DEF_SEL_W,
   parameter int ID_W   = DEF_ID_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ovf_in,
   input  logic               force_req,
   input  logic [N_SRC-1:0]   ch_mask,
   input  logic               clr_overrun,
   readout_scheduler_if.master dp,
   output logic               frame_start,
   output logic               frame_done,
   output logic               busy,
   output logic               overrun,
   output logic [ID_W-1:0]    frame_id
);

   localparam int CNT_W = $clog2(DATA_W);

   state_e           st_q;
   state_e           st_d;
   logic             ovf_q;
   logic [N_SRC-1:0] mask_q;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             pend_q;
   logic             pend_d;
   logic             ovr_q;
   logic             ovr_set;
   logic             fs_q;
   logic [ID_W-1:0]  id_q;

   logic             trig;
   logic             start;
   logic             last_bit;
   logic             first;
   logic [N_SRC-1:0] f_mask;
   logic [SEL_W-1:0] f_idx;
   logic             f_found;

   assign trig     = (ovf_in & ~ovf_q) | force_req;
   assign last_bit = (st_q == ST_SHIFT) && (bit_cnt == '0);

   // A new frame begins from IDLE on a trigger or a leftover pending
   // request, or straight out of CLEAR when one is pending.
   assign start = ((st_q == ST_IDLE) && (trig || pend_q)) ||
                  ((st_q == ST_CLEAR) && pend_q);

   // Frame start searches the live mask from -1; mid-frame searches the
   // latched mask above the current select.
   assign first  = (st_q != ST_SHIFT);
   assign f_mask = first ? ch_mask : mask_q;

   next_src_finder #(
      .N_SRC (N_SRC),
      .SEL_W (SEL_W)
   ) u_finder (
      .mask  (f_mask),
      .cur   (sel_q),
      .first (first),
      .idx   (f_idx),
      .found (f_found)
   );

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         ST_IDLE:  if (start) st_d = f_found ? ST_LOAD : ST_CLEAR;
         ST_LOAD:  st_d = ST_SHIFT;
         ST_SHIFT: if (last_bit) st_d = f_found ? ST_LOAD : ST_CLEAR;
         ST_CLEAR: begin
            if (start) st_d = f_found ? ST_LOAD : ST_CLEAR;
            else       st_d = ST_IDLE;
         end
         default:  st_d = ST_IDLE;
      endcase
   end

   // One pending slot. In CLEAR the slot is being consumed, so a trigger
   // either refills it or, if it was full, is an overrun.
   always_comb begin
      pend_d  = pend_q;
      ovr_set = 1'b0;
      if (st_q == ST_IDLE) begin
         pend_d = trig & pend_q;
      end else if (st_q == ST_CLEAR) begin
         pend_d  = trig & ~pend_q;
         ovr_set = trig & pend_q;
      end else if (trig) begin
         if (pend_q) ovr_set = 1'b1;
         else        pend_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= ST_IDLE;
         ovf_q   <= 1'b0;
         mask_q  <= '0;
         sel_q   <= '0;
         bit_cnt <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         fs_q    <= 1'b0;
         id_q    <= '0;
      end else begin
         st_q   <= st_d;
         ovf_q  <= ovf_in;
         pend_q <= pend_d;
         fs_q   <= start;
         if (start) mask_q <= ch_mask;
         if ((start || last_bit) && f_found) sel_q <= f_idx;
         if (st_q == ST_LOAD)       bit_cnt <= CNT_W'(DATA_W - 1);
         else if (st_q == ST_SHIFT) bit_cnt <= bit_cnt - 1'b1;
         if (st_q == ST_CLEAR) id_q <= id_q + 1'b1;
         if (ovr_set)          ovr_q <= 1'b1;
         else if (clr_overrun) ovr_q <= 1'b0;
      end
   end

   assign dp.sel      = sel_q;
   assign dp.sl       = (st_q == ST_LOAD);
   assign dp.shift_en = (st_q == ST_SHIFT);
   assign dp.cnt_clr  = (st_q == ST_CLEAR);
   assign frame_done  = (st_q == ST_CLEAR);
   assign frame_start = fs_q;
   assign busy        = (st_q != ST_IDLE);
   assign overrun     = ovr_q;
   assign frame_id    = id_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// Self-checking bench for readout_scheduler against a schedule model.
// Model derives per-cycle outputs from the enabled-source list arithmetic.
module tb_readout_scheduler;
   import readout_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ovf_in;
   logic        force_req;
   logic [15:0] ch_mask;
   logic        clr_overrun;
   logic        frame_start;
   logic        frame_done;
   logic        busy;
   logic        overrun;
   logic [7:0]  frame_id;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_id = '0;

   readout_scheduler_if #(.SEL_W(4)) dp ();

   readout_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .ovf_in      (ovf_in),
      .force_req   (force_req),
      .ch_mask     (ch_mask),
      .clr_overrun (clr_overrun),
      .dp          (dp),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .busy        (busy),
      .overrun     (overrun),
      .frame_id    (frame_id)
   );

   always #5 clk = ~clk;

   // Expected {fs,busy,cnt_clr,done,shift,sl,sel} at cycle k after trigger.
   function automatic logic [9:0] model(input logic [15:0] m, input int k);
      int e[16];
      int n;
      int w;
      int p;
      logic [9:0] r;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         e[i] = 0;
         if (m[i]) begin
            e[n] = i;
            n++;
         end
      end
      r = '0;
      if (k >= 1 && k <= 1 + WORD_CYCLES * n) begin
         r[8] = 1'b1;
         r[9] = (k == 1);
         if (k == 1 + WORD_CYCLES * n) begin
            r[7] = 1'b1;
            r[6] = 1'b1;
         end else begin
            w = (k - 1) / WORD_CYCLES;
            p = (k - 1) % WORD_CYCLES;
            if (p == 0) r[4] = 1'b1;
            else        r[5] = 1'b1;
            r[3:0] = 4'(e[w]);
         end
      end
      return r;
   endfunction

   function automatic logic [9:0] obs();
      logic [3:0] s;
      s = (dp.sl | dp.shift_en) ? dp.sel : 4'h0;
      return {frame_start, busy, dp.cnt_clr, frame_done,
              dp.shift_en, dp.sl, s};
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      ovf_in = 1'b0;
      force_req = 1'b0;
      ch_mask = '0;
      clr_overrun = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 10'h0 || overrun !== 1'b0 || frame_id !== 8'h0) begin
         errors++;
         $display("FAIL reset got=%h/%b/%h exp=0/0/0",
                  obs(), overrun, frame_id);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_full_mask();
      logic [15:0] m;
      int nsl;
      int nsh;
      m = 16'hFFFF;
      nsl = 0;
      nsh = 0;
      @(negedge clk);
      ch_mask = m;
      ovf_in = 1'b1;
      for (int k = 1; k <= 212; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs() !== model(m, k)) begin
            errors++;
            $display("FAIL full k=%0d got=%h exp=%h", k, obs(), model(m, k));
         end
         if (dp.sl) nsl++;
         if (dp.shift_en) nsh++;
         @(negedge clk);
         ovf_in = 1'b0;
      end
      exp_id++;
      checks++;
      if (nsl != 16 || nsh != 192 || frame_id !== exp_id) begin
         errors++;
         $display("FAIL full_totals got=%0d/%0d/%0d exp=16/192/%0d",
                  nsl, nsh, frame_id, exp_id);
      end
   endtask

   task automatic test_masks();
      logic [15:0] m;
      int n;
      for (int r = 0; r < 5; r++) begin
         m = (r == 0) ? 16'h0005 : 16'($urandom);
         n = $countones(m);
         @(negedge clk);
         ch_mask = m;
         force_req = 1'b1;
         for (int k = 1; k <= 2 + WORD_CYCLES * n; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs() !== model(m, k)) begin
               errors++;
               $display("FAIL mask %h k=%0d got=%h exp=%h",
                        m, k, obs(), model(m, k));
            end
            @(negedge clk);
            force_req = 1'b0;
            ch_mask = 16'($urandom);
         end
         exp_id++;
         checks++;
         if (frame_id !== exp_id) begin
            errors++;
            $display("FAIL mask_id got=%0d exp=%0d", frame_id, exp_id);
         end
      end
   endtask

   task automatic test_empty();
      @(negedge clk);
      ch_mask = 16'h0000;
      force_req = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs() !== model(16'h0000, k)) begin
            errors++;
            $display("FAIL empty k=%0d got=%h exp=%h",
                     k, obs(), model(16'h0000, k));
         end
         @(negedge clk);
         force_req = 1'b0;
      end
      exp_id++;
      checks++;
      if (frame_id !== exp_id) begin
         errors++;
         $display("FAIL empty_id got=%0d exp=%0d", frame_id, exp_id);
      end
   endtask

   task automatic test_overrun();
      logic [15:0] m;
      logic [9:0]  ex;
      int ndone;
      m = 16'hFFFF;
      ndone = 0;
      @(negedge clk);
      ch_mask = m;
      force_req = 1'b1;
      for (int k = 1; k <= 420; k++) begin
         @(posedge clk);
         #1;
         ex = (k <= 209) ? model(m, k) : model(m, k - 209);
         checks++;
         if (obs() !== ex || overrun !== (k >= 61)) begin
            errors++;
            $display("FAIL overrun k=%0d got=%h/%b exp=%h/%b",
                     k, obs(), overrun, ex, (k >= 61));
         end
         if (frame_done) ndone++;
         @(negedge clk);
         force_req = (k == 50 || k == 60);
      end
      exp_id += 8'd2;
      checks++;
      if (ndone != 2 || frame_id !== exp_id) begin
         errors++;
         $display("FAIL overrun_totals got=%0d/%0d exp=2/%0d",
                  ndone, frame_id, exp_id);
      end
      clr_overrun = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL clr_overrun got=%b exp=0", overrun);
      end
      @(negedge clk);
      clr_overrun = 1'b0;
   endtask

   task automatic test_ovf_level();
      logic [15:0] m;
      m = 16'h0003;
      @(negedge clk);
      ch_mask = m;
      ovf_in = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs() !== model(m, k)) begin
            errors++;
            $display("FAIL ovf_hold k=%0d got=%h exp=%h",
                     k, obs(), model(m, k));
         end
      end
      @(negedge clk);
      ovf_in = 1'b0;
      @(negedge clk);
      ovf_in = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs() !== model(m, k)) begin
            errors++;
            $display("FAIL ovf_again k=%0d got=%h exp=%h",
                     k, obs(), model(m, k));
         end
      end
      @(negedge clk);
      ovf_in = 1'b0;
      exp_id += 8'd2;
      checks++;
      if (frame_id !== exp_id) begin
         errors++;
         $display("FAIL ovf_id got=%0d exp=%0d", frame_id, exp_id);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] m;
      m = 16'hFFFF;
      @(negedge clk);
      ch_mask = m;
      force_req = 1'b1;
      for (int k = 1; k <= 95; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs() !== model(m, k)) begin
            errors++;
            $display("FAIL pre_rst k=%0d got=%h exp=%h",
                     k, obs(), model(m, k));
         end
         @(negedge clk);
         force_req = 1'b0;
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (obs() !== 10'h0 || dp.sel !== 4'h0 ||
          overrun !== 1'b0 || frame_id !== 8'h0) begin
         errors++;
         $display("FAIL async_rst got=%h/%h/%b/%h exp=0/0/0/0",
                  obs(), dp.sel, overrun, frame_id);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (dp.cnt_clr !== 1'b0 || frame_id !== 8'h0) begin
            errors++;
            $display("FAIL rst_hold got=%b/%h exp=0/0", dp.cnt_clr, frame_id);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      exp_id = '0;
      m = 16'h0081;
      @(negedge clk);
      ch_mask = m;
      force_req = 1'b1;
      for (int k = 1; k <= 28; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs() !== model(m, k)) begin
            errors++;
            $display("FAIL post_rst k=%0d got=%h exp=%h",
                     k, obs(), model(m, k));
         end
         @(negedge clk);
         force_req = 1'b0;
      end
      exp_id++;
      checks++;
      if (frame_id !== exp_id) begin
         errors++;
         $display("FAIL post_rst_id got=%0d exp=%0d", frame_id, exp_id);
      end
   endtask

   initial begin
      test_reset();
      test_full_mask();
      test_masks();
      test_empty();
      test_overrun();
      test_ovf_level();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
